// File: rtl/delay_temp_unit.sv
// delay_temp_unit
//   Two independent blocks sharing one clock:
//   * A prescaled delay counter. A start loads a tick count. Each tick is
//     PRESCALE enabled clock cycles. delay_done rises when the count runs out.
//   * An 8-bit signed temp register. It supports load, increment and
//     decrement, and drives sign/zero flags.
//
// Parameters
//   PRESCALE  clk cycles per delay tick (>= 2)
//   DELAY_W   width of delay_value and of the remaining-tick counter
//
// Ports
//   clk                      sole clock, rising edge
//   reset                    asynchronous, active-high
//   start_delay_counter      load delay_value and begin a new delay (beats enable)
//   enable_delay_counter     advance the running delay this cycle
//   delay_value[DELAY_W]     delay length in ticks, sampled on start
//   delay_done               registered, high while the delay has expired
//   delay_busy               registered, high while a delay is counting
//   load_temp_register       temp <= temp_load_value (highest priority)
//   increment_temp_register  temp <= temp + 1
//   decrement_temp_register  temp <= temp - 1
//   temp_load_value[8]       signed load data
//   temp_value[8]            current signed temp register
//   temp_is_positive/_negative/_zero  combinational flags from temp_value
module delay_temp_unit #(
  parameter int PRESCALE = 50000,
  parameter int DELAY_W  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_delay_counter,
  input  logic               enable_delay_counter,
  input  logic [DELAY_W-1:0] delay_value,
  output logic               delay_done,
  output logic               delay_busy,
  input  logic               load_temp_register,
  input  logic               increment_temp_register,
  input  logic               decrement_temp_register,
  input  logic [7:0]         temp_load_value,
  output logic [7:0]         temp_value,
  output logic               temp_is_positive,
  output logic               temp_is_negative,
  output logic               temp_is_zero
);

  localparam int PRE_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [PRE_W-1:0]   prescale_reg, prescale_next;
  logic [DELAY_W-1:0] remaining_reg, remaining_next;
  logic               done_reg, busy_reg;
  logic [7:0]         temp_reg, temp_next;

  // ---------------- delay counter ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      prescale_reg  <= '0;
      remaining_reg <= '0;
      done_reg      <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      prescale_reg  <= prescale_next;
      remaining_reg <= remaining_next;
      // The flags are decoded from the next state. They then change on the
      // same edge as the state they describe.
      done_reg      <= (state_next == DONE);
      busy_reg      <= (state_next == COUNT);
    end
  end

  always_comb begin
    state_next     = state_reg;
    prescale_next  = prescale_reg;
    remaining_next = remaining_reg;

    if (start_delay_counter) begin
      state_next     = COUNT;
      prescale_next  = '0;
      remaining_next = delay_value;
    end else begin
      case (state_reg)
        COUNT: begin
          // A zero-length delay finishes on the first edge, whether or not
          // enable is high.
          if (remaining_reg == '0) begin
            state_next = DONE;
          end else if (enable_delay_counter) begin
            if (prescale_reg == PRE_LAST) begin
              prescale_next  = '0;
              remaining_next = remaining_reg - DELAY_W'(1);
              if (remaining_reg == DELAY_W'(1)) begin
                state_next = DONE;
              end
            end else begin
              prescale_next = prescale_reg + PRE_W'(1);
            end
          end
          // With enable low, everything holds, so a pause loses no progress.
        end
        DONE:    state_next = DONE;   // sticky until start or reset
        default: state_next = IDLE;   // IDLE ignores enable
      endcase
    end
  end

  assign delay_done = done_reg;
  assign delay_busy = busy_reg;

  // ---------------- temp register ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      temp_reg <= '0;
    end else begin
      temp_reg <= temp_next;
    end
  end

  // Load wins. Increment and decrement together cancel out. Arithmetic
  // wraps modulo 256.
  always_comb begin
    temp_next = temp_reg;
    if (load_temp_register) begin
      temp_next = temp_load_value;
    end else if (increment_temp_register && !decrement_temp_register) begin
      temp_next = temp_reg + 8'd1;
    end else if (decrement_temp_register && !increment_temp_register) begin
      temp_next = temp_reg - 8'd1;
    end
  end

  assign temp_value       = temp_reg;
  assign temp_is_zero     = (temp_reg == 8'd0);
  assign temp_is_negative = temp_reg[7];
  assign temp_is_positive = !temp_is_zero && !temp_reg[7];

endmodule
